// File: rtl/lq_alloc_ctrl.sv
// Load-queue tag allocator: hands out {flipped, idx} tags in program order from the tail,
// retires from the head on commit, and rolls the tail back on squash.
module lq_alloc_ctrl #(
  parameter  int SIZE          = 64,
  parameter  int ALLOC_WIDTH   = 4,
  parameter  int DEALLOC_WIDTH = 4,
  localparam int IDXW          = $clog2(SIZE),
  localparam int PTRW          = IDXW + 1,
  localparam int CNTW          = $clog2(SIZE + 1),
  localparam int DNW           = $clog2(DEALLOC_WIDTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ALLOC_WIDTH-1:0]          i_alloc_vld,
  output logic                            o_can_alloc,
  output logic [ALLOC_WIDTH-1:0][PTRW-1:0] o_alloc_lqIdx,
  input  logic [DNW-1:0]                  i_dealloc_num,
  input  logic                            i_squash,
  input  logic [PTRW-1:0]                 i_squash_lqIdx,
  output logic [PTRW-1:0]                 o_head,
  output logic [PTRW-1:0]                 o_tail,
  output logic [CNTW-1:0]                 o_count,
  output logic                            o_empty,
  output logic                            o_full
);

  logic [PTRW-1:0] head_q, head_d;
  logic [PTRW-1:0] tail_q, tail_d;
  logic            can_alloc_q, can_alloc_d;
  logic [PTRW-1:0] count, count_nxt;
  logic [PTRW-1:0] alloc_num;
  logic            alloc_acc;

  // SIZE is a power of two, so a plain PTRW-bit add wraps idx and toggles the flip bit.
  assign count     = tail_q - head_q;
  assign count_nxt = tail_d - head_d;
  assign alloc_acc = can_alloc_q & (|i_alloc_vld) & ~i_squash;

  always_comb begin
    alloc_num     = '0;
    o_alloc_lqIdx = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      o_alloc_lqIdx[i] = tail_q + alloc_num;
      alloc_num        = alloc_num + PTRW'(i_alloc_vld[i]);
    end
  end

  always_comb begin
    head_d = head_q + PTRW'(i_dealloc_num);
    tail_d = tail_q;
    if (i_squash) begin
      tail_d = i_squash_lqIdx;
    end else if (alloc_acc) begin
      tail_d = tail_q + alloc_num;
    end
    // Registered, so a retire this cycle only frees space for allocation next cycle.
    can_alloc_d = (32'(SIZE) - 32'(count_nxt)) >= 32'(ALLOC_WIDTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      can_alloc_q <= 1'b1;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      can_alloc_q <= can_alloc_d;
    end
  end

  assign o_can_alloc = can_alloc_q;
  assign o_head      = head_q;
  assign o_tail      = tail_q;
  assign o_count     = CNTW'(count);
  assign o_empty     = (count == '0);
  assign o_full      = (count == PTRW'(SIZE));

  // Squash target must lie in [head + retired, tail]; offsets are taken from the new head.
  logic [PTRW-1:0] head_ret, sq_off, live_ret;
  assign head_ret = head_q + PTRW'(i_dealloc_num);
  assign sq_off   = i_squash_lqIdx - head_ret;
  assign live_ret = tail_q - head_ret;

  a_dealloc_le_count : assert property (@(posedge clk) disable iff (rst)
    (32'(i_dealloc_num) <= DEALLOC_WIDTH) && (PTRW'(i_dealloc_num) <= count));
  a_squash_in_range : assert property (@(posedge clk) disable iff (rst)
    !i_squash || (sq_off <= live_ret));

endmodule

// File: tb/tb_lq_alloc_ctrl.sv
// Directed bench for lq_alloc_ctrl: a vector table for single-cycle behaviour plus
// hand-written sequences for fill/full, wrap, squash-to-empty and mid-operation reset.
module tb_lq_alloc_ctrl;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       i_alloc_vld;
  logic             o_can_alloc;
  logic [3:0][6:0]  o_alloc_lqIdx;
  logic [2:0]       i_dealloc_num;
  logic             i_squash;
  logic [6:0]       i_squash_lqIdx;
  logic [6:0]       o_head, o_tail, o_count;
  logic             o_empty, o_full;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  lq_alloc_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .i_alloc_vld    (i_alloc_vld),
    .o_can_alloc    (o_can_alloc),
    .o_alloc_lqIdx  (o_alloc_lqIdx),
    .i_dealloc_num  (i_dealloc_num),
    .i_squash       (i_squash),
    .i_squash_lqIdx (i_squash_lqIdx),
    .o_head         (o_head),
    .o_tail         (o_tail),
    .o_count        (o_count),
    .o_empty        (o_empty),
    .o_full         (o_full)
  );

  typedef struct {
    logic [3:0]      vld;
    logic [2:0]      dn;
    logic            sq;
    logic [6:0]      sq_idx;
    logic [6:0]      e_head;
    logic [6:0]      e_tail;
    logic [6:0]      e_cnt;
    logic            e_can;
    logic [3:0][6:0] e_tags;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(logic [3:0] vld, logic [2:0] dn, logic sq, logic [6:0] sq_idx,
                              logic [6:0] h, logic [6:0] t, logic [6:0] c, logic can,
                              logic [27:0] tags);
    vec_t v;
    v.vld = vld; v.dn = dn; v.sq = sq; v.sq_idx = sq_idx;
    v.e_head = h; v.e_tail = t; v.e_cnt = c; v.e_can = can; v.e_tags = tags;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_state(input string tag, input int h, input int t, input int c, input int can);
    check({tag, " head"}, int'(o_head), h);
    check({tag, " tail"}, int'(o_tail), t);
    check({tag, " count"}, int'(o_count), c);
    check({tag, " empty"}, int'(o_empty), (c == 0) ? 1 : 0);
    check({tag, " full"}, int'(o_full), (c == 64) ? 1 : 0);
    check({tag, " can_alloc"}, int'(o_can_alloc), can);
  endtask

  task automatic drive(input logic [3:0] vld, input logic [2:0] dn, input logic sq,
                       input logic [6:0] idx);
    i_alloc_vld = vld; i_dealloc_num = dn; i_squash = sq; i_squash_lqIdx = idx;
  endtask

  task automatic step(input logic [3:0] vld, input logic [2:0] dn, input logic sq,
                      input logic [6:0] idx);
    @(negedge clk);
    drive(vld, dn, sq, idx);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // State columns are the expected values before the edge that consumes the row's inputs.
    vecs[0]  = mk(4'h0, 3'd0, 1'b0, 7'd0, 7'd0, 7'd0,  7'd0,  1'b1, 28'd0);
    vecs[1]  = mk(4'hF, 3'd0, 1'b0, 7'd0, 7'd0, 7'd0,  7'd0,  1'b1, {7'd3, 7'd2, 7'd1, 7'd0});
    vecs[2]  = mk(4'hF, 3'd0, 1'b0, 7'd0, 7'd0, 7'd4,  7'd4,  1'b1, {7'd7, 7'd6, 7'd5, 7'd4});
    vecs[3]  = mk(4'h3, 3'd0, 1'b0, 7'd0, 7'd0, 7'd8,  7'd8,  1'b1, {7'd0, 7'd0, 7'd9, 7'd8});
    vecs[4]  = mk(4'hA, 3'd0, 1'b0, 7'd0, 7'd0, 7'd10, 7'd10, 1'b1, {7'd11, 7'd0, 7'd10, 7'd0});
    vecs[5]  = mk(4'hF, 3'd4, 1'b0, 7'd0, 7'd0, 7'd12, 7'd12, 1'b1, {7'd15, 7'd14, 7'd13, 7'd12});
    vecs[6]  = mk(4'hF, 3'd1, 1'b0, 7'd0, 7'd4, 7'd16, 7'd12, 1'b1, {7'd19, 7'd18, 7'd17, 7'd16});
    vecs[7]  = mk(4'hF, 3'd0, 1'b1, 7'd8, 7'd5, 7'd20, 7'd15, 1'b1, {7'd23, 7'd22, 7'd21, 7'd20});
    vecs[8]  = mk(4'h0, 3'd0, 1'b1, 7'd8, 7'd5, 7'd8,  7'd3,  1'b1, 28'd0);
    vecs[9]  = mk(4'h0, 3'd3, 1'b0, 7'd0, 7'd5, 7'd8,  7'd3,  1'b1, 28'd0);
    vecs[10] = mk(4'h0, 3'd0, 1'b0, 7'd0, 7'd8, 7'd8,  7'd0,  1'b1, 28'd0);

    rst = 1'b1;
    drive(4'h0, 3'd0, 1'b0, 7'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int v = 0; v < 11; v++) begin
      @(negedge clk);
      drive(vecs[v].vld, vecs[v].dn, vecs[v].sq, vecs[v].sq_idx);
      #1;
      chk_state($sformatf("vec%0d", v), int'(vecs[v].e_head), int'(vecs[v].e_tail),
                int'(vecs[v].e_cnt), int'(vecs[v].e_can));
      for (int k = 0; k < 4; k++)
        if (vecs[v].vld[k])
          check($sformatf("vec%0d tag%0d", v, k), int'(o_alloc_lqIdx[k]), int'(vecs[v].e_tags[k]));
      @(posedge clk);
    end

    // Fill to 61 -> can_alloc drops; retire 4 -> 57 and can_alloc returns.
    for (int i = 0; i < 15; i++) step(4'hF, 3'd0, 1'b0, 7'd0);
    chk_state("fill60", 8, 68, 60, 1);
    step(4'h1, 3'd0, 1'b0, 7'd0);
    chk_state("fill61", 8, 69, 61, 0);
    step(4'h0, 3'd4, 1'b0, 7'd0);
    chk_state("retire57", 12, 69, 57, 1);
    step(4'h7, 3'd0, 1'b0, 7'd0);
    chk_state("refill60", 12, 72, 60, 1);
    step(4'hF, 3'd0, 1'b0, 7'd0);
    chk_state("full64", 12, 76, 64, 0);
    // Full with simultaneous retire: request is ignored because can_alloc is still low.
    step(4'hF, 3'd4, 1'b0, 7'd0);
    chk_state("full_retire", 16, 76, 60, 1);
    for (int i = 0; i < 5; i++) step(4'h0, 3'd4, 1'b0, 7'd0);
    chk_state("cnt40", 36, 76, 40, 1);

    @(negedge clk);
    rst = 1'b1;
    drive(4'hF, 3'd2, 1'b0, 7'd0);
    @(posedge clk);
    #1;
    chk_state("midrst", 0, 0, 0, 1);
    @(negedge clk);
    rst = 1'b0;
    drive(4'h0, 3'd0, 1'b0, 7'd0);

    // Walk the pointers up to tail={0,62}, then allocate across the wrap.
    for (int i = 0; i < 15; i++) step(4'hF, (i == 0) ? 3'd0 : 3'd4, 1'b0, 7'd0);
    step(4'h3, 3'd0, 1'b0, 7'd0);
    chk_state("pre_wrap", 56, 62, 6, 1);
    @(negedge clk);
    drive(4'hF, 3'd0, 1'b0, 7'd0);
    #1;
    check("wrap tag0", int'(o_alloc_lqIdx[0]), 62);
    check("wrap tag1", int'(o_alloc_lqIdx[1]), 63);
    check("wrap tag2", int'(o_alloc_lqIdx[2]), 64);
    check("wrap tag3", int'(o_alloc_lqIdx[3]), 65);
    @(posedge clk);
    #1;
    chk_state("post_wrap", 56, 66, 10, 1);

    // head={1,3}, tail={1,9}; retire 2 and squash to {1,5} -> empty.
    step(4'h7, 3'd4, 1'b0, 7'd0);
    step(4'hF, 3'd4, 1'b0, 7'd0);
    step(4'h0, 3'd3, 1'b0, 7'd0);
    chk_state("pre_sq", 67, 73, 6, 1);
    step(4'h0, 3'd2, 1'b1, 7'd69);
    chk_state("sq_empty", 69, 69, 0, 1);
    step(4'h0, 3'd0, 1'b0, 7'd0);
    chk_state("idle", 69, 69, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
